// File: rtl/sdadc_window_ctrl.sv
// Sigma-delta ADC loop sequencer with boxcar (ones-count) decimation over 2^WIN_LOG2-cycle windows.
// Latency: first o_valid SETTLE_CYCLES+2^WIN_LOG2 edges after the IDLE edge that sees i_run=1.
// Backpressure: single output register; a window finishing while o_valid&&!i_ready is dropped (sticky o_overrun).
//
// Ports:
//   i_clk, i_rst            sole clock, synchronous active-high reset
//   i_run                   1 = convert continuously, 0 = return to IDLE
//   i_analog / o_digital    comparator bit in, registered feedback bit out
//   o_sample/o_valid/i_ready  window result handshake
//   o_busy, o_overrun       state != IDLE, sticky dropped-window flag
module sdadc_window_ctrl #(
    parameter int WIN_LOG2      = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_analog,
    output logic              o_digital,
    output logic [WIN_LOG2:0] o_sample,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int                SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]     SETTLE_INIT = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [WIN_LOG2-1:0] WIN_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_INTEGRATE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SW-1:0]       r_settle_cnt;
    logic [SW-1:0]       w_settle_nxt;
    logic [WIN_LOG2:0]   r_acc;
    logic [WIN_LOG2:0]   w_acc_nxt;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [WIN_LOG2-1:0] w_win_nxt;
    logic                r_digital;
    logic [WIN_LOG2:0]   r_sample;
    logic                r_valid;
    logic                r_busy;
    logic                r_overrun;
    logic                w_result_vld;
    logic [WIN_LOG2:0]   w_result;

    assign o_digital = r_digital;
    assign o_sample  = r_sample;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_acc_nxt    = r_acc;
        w_win_nxt    = r_win_cnt;
        w_result_vld = 1'b0;
        // The bit being accumulated is the feedback already registered, not i_analog.
        w_result     = r_acc + {{WIN_LOG2{1'b0}}, r_digital};

        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_acc_nxt = '0;
                    w_win_nxt = '0;
                    if (SETTLE_CYCLES == 0) begin
                        w_state_nxt = S_INTEGRATE;
                    end else begin
                        w_state_nxt  = S_SETTLE;
                        w_settle_nxt = SETTLE_INIT;
                    end
                end
            end
            S_SETTLE: begin
                if (!i_run) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle_cnt == '0) begin
                    w_state_nxt = S_INTEGRATE;
                    w_acc_nxt   = '0;
                    w_win_nxt   = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt - SW'(1);
                end
            end
            S_INTEGRATE: begin
                if (r_win_cnt == WIN_LAST) begin
                    // Window complete: result is emitted even if i_run drops on this edge.
                    w_result_vld = 1'b1;
                    w_acc_nxt    = '0;
                    w_win_nxt    = '0;
                    if (!i_run) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!i_run) begin
                    // Partial window discarded.
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_win_nxt   = '0;
                end else begin
                    w_acc_nxt = w_result;
                    w_win_nxt = r_win_cnt + WIN_LOG2'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_acc        <= '0;
            r_win_cnt    <= '0;
            r_digital    <= 1'b0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_acc        <= w_acc_nxt;
            r_win_cnt    <= w_win_nxt;
            r_digital    <= i_analog;
            r_busy       <= (w_state_nxt != S_IDLE);

            // Output register: load when empty or being drained this edge; otherwise drop and flag.
            if (w_result_vld) begin
                if (!r_valid || i_ready) begin
                    r_sample <= w_result;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdadc_window_ctrl.sv
`timescale 1ns/1ps
module tb_sdadc_window_ctrl;

    localparam int WL = 4;
    localparam int S  = 2;
    localparam int W  = 1 << WL;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_run = 1'b0;
    logic          i_analog = 1'b0;
    logic          i_ready = 1'b1;
    logic          o_digital;
    logic [WL:0]   o_sample;
    logic          o_valid;
    logic          o_busy;
    logic          o_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sdadc_window_ctrl #(.WIN_LOG2(WL), .SETTLE_CYCLES(S)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_run     (i_run),
        .i_analog  (i_analog),
        .o_digital (o_digital),
        .o_sample  (o_sample),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: edges since start, and the window's bits kept in a queue.
    bit        m_active = 0;
    int        m_t = 0;
    int        m_bits[$];
    bit        m_dig = 0;
    logic [WL:0] m_sample = '0;
    bit        m_valid = 0;
    bit        m_busy = 0;
    bit        m_ovr = 0;

    function automatic void model_step(bit r, bit run, bit a, bit rdy);
        int res = 0;
        bit res_vld = 0;
        if (r) begin
            m_active = 0; m_t = 0; m_bits.delete();
            m_dig = 0; m_sample = '0; m_valid = 0; m_busy = 0; m_ovr = 0;
            return;
        end
        if (!m_active) begin
            if (run) begin
                m_active = 1; m_t = 0; m_bits.delete();
            end
        end else begin
            m_t++;
            if (m_t <= S) begin
                if (!run) m_active = 0;
            end else begin
                m_bits.push_back(int'(m_dig));
                if (m_bits.size() == W) begin
                    foreach (m_bits[k]) res += m_bits[k];
                    res_vld = 1;
                    m_bits.delete();
                    if (!run) m_active = 0;
                end else if (!run) begin
                    m_active = 0;
                    m_bits.delete();
                end
            end
        end
        m_busy = m_active;
        if (res_vld) begin
            if (!m_valid || rdy) begin
                m_sample = res[WL:0];
                m_valid  = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_dig = a;
    endfunction

    function automatic logic [WL+4:0] dut_vec();
        return {o_digital, o_sample, o_valid, o_busy, o_overrun};
    endfunction

    function automatic logic [WL+4:0] mdl_vec();
        return {m_dig, m_sample, m_valid, m_busy, m_ovr};
    endfunction

    // Advance one edge: inputs sampled as they stand before the edge, outputs settle #1 after.
    task automatic tick();
        bit r   = i_rst;
        bit run = i_run;
        bit a   = i_analog;
        bit rdy = i_ready;
        @(posedge i_clk);
        model_step(r, run, a, rdy);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_run = 1'b0; i_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_run = 1'b1; i_analog = 1'b1;
        tick();
        tick();
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", dut_vec());
        end
        i_run = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reset_idle_loop got %h exp %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_all_ones();
        int n;
        do_reset();
        i_analog = 1'b1; i_run = 1'b1; i_ready = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ones_busy got %b exp 1", o_busy);
        end
        n = 0;
        while (o_valid !== 1'b1 && n < 60) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL ones_model cyc %0d got %h exp %h", cyc, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (n != S + W) begin
            errors++;
            $display("FAIL ones_latency got %0d exp %0d", n, S + W);
        end
        checks++;
        if (o_sample !== 5'd16) begin
            errors++;
            $display("FAIL ones_sample got %0d exp 16", o_sample);
        end
        for (int w = 0; w < 2; w++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL ones_single_cycle got %b exp 0", o_valid);
            end
            n = 1;
            while (o_valid !== 1'b1 && n < 60) begin
                tick(); n++;
            end
            checks++;
            if (n != W || o_sample !== 5'd16) begin
                errors++;
                $display("FAIL ones_period got %0d/%0d exp %0d/16", n, o_sample, W);
            end
        end
    endtask

    task automatic test_patterns();
        int n;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            i_analog = 1'b0; i_run = 1'b1;
            for (int k = 0; k < 60; k++) begin
                if (p == 1) i_analog = ~i_analog;
                tick();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL pattern%0d_model cyc %0d got %h exp %h", p, cyc, dut_vec(), mdl_vec());
                end
                if (o_valid === 1'b1) begin
                    checks++;
                    if (o_sample !== ((p == 0) ? 5'd0 : 5'd8)) begin
                        errors++;
                        $display("FAIL pattern%0d_sample got %0d exp %0d", p, o_sample, (p == 0) ? 0 : 8);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        i_analog = 1'b1; i_run = 1'b1; i_ready = 1'b0;
        tick();
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL bp_model cyc %0d got %h exp %h", cyc, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (o_valid !== 1'b1 || o_sample !== 5'd16 || o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_held got v%b s%0d o%b exp v1 s16 o1", o_valid, o_sample, o_overrun);
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got %b exp 0", o_valid);
        end
        n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
            tick(); n++;
        end
        checks++;
        if (o_valid !== 1'b1 || o_sample !== 5'd16 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL bp_resume got %h exp %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_stop();
        int n;
        do_reset();
        i_run = 1'b1;
        n = 0;
        while (o_valid !== 1'b1 && n < 60) begin
            i_analog = 1'($urandom);
            tick(); n++;
        end
        for (int k = 0; k < 10; k++) begin
            i_analog = 1'($urandom);
            tick();
        end
        i_run = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_busy got %b exp 0", o_busy);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL stop_no_result cyc %0d got %h exp %h", cyc, dut_vec(), mdl_vec());
            end
        end
        i_run = 1'b1;
        tick();
        n = 0;
        while (o_valid !== 1'b1 && n < 60) begin
            tick(); n++;
        end
        checks++;
        if (n != S + W) begin
            errors++;
            $display("FAIL stop_restart_latency got %0d exp %0d", n, S + W);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_analog = 1'b1; i_run = 1'b1; i_ready = 1'b0;
        for (int k = 0; k < 41; k++) tick();
        checks++;
        if (o_valid !== 1'b1 || o_overrun !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup got v%b o%b b%b exp 1 1 1", o_valid, o_overrun, o_busy);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h exp 0", dut_vec());
        end
        i_rst = 1'b0; i_run = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL rstmid_idle got %h exp %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        i_analog = 1'b1; i_run = 1'b1; i_ready = 1'b0;
        tick();
        n = 0;
        while (o_valid !== 1'b1 && n < 60) begin
            tick(); n++;
        end
        i_analog = 1'b0;
        for (int k = 0; k < W - 1; k++) tick();
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_overrun !== 1'b0 || o_sample !== 5'd1) begin
            errors++;
            $display("FAIL b2b_load got v%b o%b s%0d exp v1 o0 s1", o_valid, o_overrun, o_sample);
        end
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL b2b_model got %h exp %h", dut_vec(), mdl_vec());
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b exp 0", o_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            i_analog = 1'($urandom);
            i_ready  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 3) i_run = ~i_run;
            i_rst = ($urandom_range(0, 499) == 0);
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random_model cyc %0d got %h exp %h", cyc, dut_vec(), mdl_vec());
            end
        end
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_backpressure();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
